// File: rtl/prev_frame_store_pkg.sv
// rtl/prev_frame_store_pkg.sv - shared constants for the frame-difference pipeline
// Holds the pixel width, default frame geometry and the frame pixel-count
// helper used by prev_frame_store and the diff stage.
// Optional feature macro used by the top level: DIFF_FIRST_FRAME_MASK_EN.
package prev_frame_store_pkg;
  localparam int PIX_W      = 8;
  localparam int DEF_H_PIX  = 640;
  localparam int DEF_V_PIX  = 480;
  localparam int DEF_ADDR_W = 19;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic int frame_pix_cnt(input int h_pix, input int v_pix);
    return h_pix * v_pix;
  endfunction
endpackage

// File: rtl/prev_frame_store_addr_gen.sv
// rtl/prev_frame_store_addr_gen.sv - frame start detect, pixel address, overflow and prev_ok
// Ports:
//   sys_clk, sys_rst_n  clock, synchronous active-low reset
//   pre_vsync           frame sync, rising edge starts a frame
//   pre_wr_en           pixel-valid strobe
//   pix_ok              pixel in this cycle is accepted (in range, not in reset)
//   pix_addr            RAM address of the pixel in this cycle
//   prev_ok             previous frame held exactly H_PIX*V_PIX pixels
//   frame_ovf           sticky overflow, cleared at the next frame start
module prev_frame_store_addr_gen
  import prev_frame_store_pkg::*;
#(
  parameter int H_PIX  = DEF_H_PIX,
  parameter int V_PIX  = DEF_V_PIX,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pre_vsync,
  input  logic              pre_wr_en,
  output logic              pix_ok,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              prev_ok,
  output logic              frame_ovf
);
  // One extra bit so the "frame full" value is representable even when
  // 2**ADDR_W equals the frame size exactly.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(frame_pix_cnt(H_PIX, V_PIX));

  logic             vs_d;
  logic             sof;
  logic [CNT_W-1:0] addr;
  logic [CNT_W-1:0] addr_cur;

  // A pixel arriving in the sof cycle already belongs to the new frame.
  always_comb begin
    sof      = pre_vsync & ~vs_d;
    addr_cur = sof ? '0 : addr;
    pix_ok   = sys_rst_n & pre_wr_en & (addr_cur < FRAME_CNT);
    pix_addr = addr_cur[ADDR_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      vs_d      <= 1'b0;
      addr      <= '0;
      prev_ok   <= 1'b0;
      frame_ovf <= 1'b0;
    end else begin
      vs_d <= pre_vsync;
      if (sof) begin
        prev_ok   <= (addr == FRAME_CNT) && !frame_ovf;
        frame_ovf <= 1'b0;
      end else if (pre_wr_en && !pix_ok) begin
        frame_ovf <= 1'b1;
      end
      if (pix_ok) begin
        addr <= addr_cur + 1'b1;
      end else if (sof) begin
        addr <= '0;
      end
    end
  end
endmodule

// File: rtl/prev_frame_store.sv
// rtl/prev_frame_store.sv - stores current frame in RAM, returns co-located previous-frame pixel
// Ports:
//   sys_clk, sys_rst_n       clock, synchronous active-low reset
//   pre_vsync, pre_wr_en     frame sync and pixel strobe from gray conversion
//   new_pic                  current-frame gray pixel
//   ram_rd_en/addr/data      RAM read port (1 clock read latency)
//   ram_wr_en/addr/data      RAM write port
//   last_pic, last_valid     previous-frame pixel, 1 clock after pre_wr_en
//   prev_ok, frame_ovf       frame status
// Macro DIFF_FIRST_FRAME_MASK_EN: when defined, last_pic echoes the delayed
// new_pic while prev_ok=0 so the diff stage sees zero difference.
module prev_frame_store
  import prev_frame_store_pkg::*;
#(
  parameter int H_PIX  = DEF_H_PIX,
  parameter int V_PIX  = DEF_V_PIX,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pre_vsync,
  input  logic              pre_wr_en,
  input  logic [PIX_W-1:0]  new_pic,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [PIX_W-1:0]  ram_rd_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [PIX_W-1:0]  ram_wr_data,
  output logic [PIX_W-1:0]  last_pic,
  output logic              last_valid,
  output logic              prev_ok,
  output logic              frame_ovf
);
  logic              pix_ok;
  logic [ADDR_W-1:0] pix_addr;
  pix_t              last_hold;

  prev_frame_store_addr_gen #(
    .H_PIX  (H_PIX),
    .V_PIX  (V_PIX),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pre_vsync (pre_vsync),
    .pre_wr_en (pre_wr_en),
    .pix_ok    (pix_ok),
    .pix_addr  (pix_addr),
    .prev_ok   (prev_ok),
    .frame_ovf (frame_ovf)
  );

  assign ram_rd_en   = pix_ok;
  assign ram_rd_addr = pix_ok ? pix_addr : '0;

  // The write trails the read by one clock, so a same-address slot always
  // reads the old frame's pixel before overwriting it.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      last_hold   <= '0;
    end else begin
      ram_wr_en <= pix_ok;
      if (pix_ok) begin
        ram_wr_addr <= pix_addr;
        ram_wr_data <= new_pic;
      end
      last_hold <= last_pic;
    end
  end

  // ram_wr_en doubles as the registered read strobe: read data is valid
  // exactly in the cycle the matching write is issued.
  always_comb begin
    last_pic = last_hold;
    if (ram_wr_en) begin
`ifdef DIFF_FIRST_FRAME_MASK_EN
      last_pic = prev_ok ? ram_rd_data : ram_wr_data;
`else
      last_pic = ram_rd_data;
`endif
    end
  end

  assign last_valid = ram_wr_en & prev_ok;
endmodule

// File: tb/tb_prev_frame_store.sv
// tb/tb_prev_frame_store.sv - randomized model-checked bench for prev_frame_store
module tb_prev_frame_store;
  localparam int H_PIX  = 4;
  localparam int V_PIX  = 2;
  localparam int ADDR_W = 3;
  localparam int FRAME  = H_PIX * V_PIX;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              pre_vsync = 1'b0;
  logic              pre_wr_en = 1'b0;
  logic [7:0]        new_pic = 8'd0;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [7:0]        ram_rd_data;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [7:0]        ram_wr_data;
  logic [7:0]        last_pic;
  logic              last_valid;
  logic              prev_ok;
  logic              frame_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pixel count in current frame, overflow seen,
  // previous-frame validity, last vsync level, expected RAM image.
  int         m_cnt;
  bit         m_ovf;
  bit         m_prev_ok;
  bit         m_vs;
  logic [7:0] m_last;
  logic [7:0] gm [FRAME];

  // Behavioural dual-port RAM, 1 clock read latency.
  logic [7:0] ram [FRAME];
  logic [7:0] ram_q = 8'd0;
  assign ram_rd_data = ram_q;
  always @(posedge sys_clk) begin
    if (ram_rd_en) ram_q <= ram[ram_rd_addr];
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
  end

  always #5 sys_clk = ~sys_clk;

  prev_frame_store #(
    .H_PIX  (H_PIX),
    .V_PIX  (V_PIX),
    .ADDR_W (ADDR_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pre_vsync   (pre_vsync),
    .pre_wr_en   (pre_wr_en),
    .new_pic     (new_pic),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .last_pic    (last_pic),
    .last_valid  (last_valid),
    .prev_ok     (prev_ok),
    .frame_ovf   (frame_ovf)
  );

  // One clock slot: drive inputs, compare against the frame-level model.
  task automatic step(input bit rst_n, input bit vs, input bit we, input logic [7:0] pix);
    bit         ex_rd;
    int         ex_addr;
    logic [7:0] ex_pic;
    sys_rst_n = rst_n;
    pre_vsync = vs;
    pre_wr_en = we;
    new_pic   = pix;
    ex_rd   = 1'b0;
    ex_addr = 0;
    if (rst_n) begin
      if (vs && !m_vs) begin
        m_prev_ok = (m_cnt == FRAME) && !m_ovf;
        m_cnt     = 0;
        m_ovf     = 1'b0;
      end
      ex_rd   = we && (m_cnt < FRAME);
      ex_addr = m_cnt;
    end
    #1;
    n_checks++;
    if (ram_rd_en !== ex_rd) $display("FAIL rd_en: got %b want %b", ram_rd_en, ex_rd);
    else n_pass++;
    if (ex_rd) begin
      n_checks++;
      if (ram_rd_addr !== ADDR_W'(ex_addr)) $display("FAIL rd_addr: got %0d want %0d", ram_rd_addr, ex_addr);
      else n_pass++;
    end
    @(posedge sys_clk);
    #1;
    if (!rst_n) begin
      m_cnt = 0; m_ovf = 1'b0; m_prev_ok = 1'b0; m_vs = 1'b0; m_last = 8'd0;
      n_checks++;
      if ({ram_wr_en, ram_wr_addr, ram_wr_data, last_pic, last_valid, prev_ok, frame_ovf} !== '0)
        $display("FAIL reset_outputs: got wr_en=%b wr_addr=%0d wr_data=%0d last_pic=%0d last_valid=%b prev_ok=%b ovf=%b want all 0",
                 ram_wr_en, ram_wr_addr, ram_wr_data, last_pic, last_valid, prev_ok, frame_ovf);
      else n_pass++;
    end else begin
      m_vs = vs;
      if (ex_rd) begin
        ex_pic = gm[ex_addr];
`ifdef DIFF_FIRST_FRAME_MASK_EN
        if (!m_prev_ok) ex_pic = pix;
`endif
        m_last = ex_pic;
        gm[ex_addr] = pix;
        m_cnt++;
      end else if (we) begin
        m_ovf = 1'b1;
      end
      n_checks++;
      if (ram_wr_en !== ex_rd) $display("FAIL wr_en: got %b want %b", ram_wr_en, ex_rd);
      else n_pass++;
      if (ex_rd) begin
        n_checks++;
        if (ram_wr_addr !== ADDR_W'(ex_addr) || ram_wr_data !== pix)
          $display("FAIL wr_addr_data: got %0d/%0d want %0d/%0d", ram_wr_addr, ram_wr_data, ex_addr, pix);
        else n_pass++;
      end
      n_checks++;
      if (last_pic !== m_last) $display("FAIL last_pic: got %0d want %0d", last_pic, m_last);
      else n_pass++;
      n_checks++;
      if (last_valid !== (ex_rd && m_prev_ok)) $display("FAIL last_valid: got %b want %b", last_valid, ex_rd && m_prev_ok);
      else n_pass++;
      n_checks++;
      if (prev_ok !== m_prev_ok || frame_ovf !== m_ovf)
        $display("FAIL status: got prev_ok=%b ovf=%b want %b %b", prev_ok, frame_ovf, m_prev_ok, m_ovf);
      else n_pass++;
    end
  endtask

  task automatic vsync_pulse();
    step(1, 0, 0, 8'd0);
    step(1, 1, 0, 8'd0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 8'd0);
    step(0, 1, 1, 8'd99);
    step(1, 0, 0, 8'd0);
  endtask

  task automatic test_frame0();
    vsync_pulse();
    for (int i = 0; i < FRAME; i++) begin
      step(1, 0, 1, 8'(10 + i));
      n_checks++;
      if (ram_wr_addr !== ADDR_W'(i) || ram_wr_data !== 8'(10 + i) || last_valid !== 1'b0)
        $display("FAIL frame0_px%0d: got addr=%0d data=%0d lv=%b want %0d %0d 0", i, ram_wr_addr, ram_wr_data, last_valid, i, 10 + i);
      else n_pass++;
    end
  endtask

  task automatic test_frame1();
    vsync_pulse();
    n_checks++;
    if (prev_ok !== 1'b1) $display("FAIL frame1_prev_ok: got %b want 1", prev_ok);
    else n_pass++;
    for (int i = 0; i < FRAME; i++) begin
      step(1, 0, 1, 8'(20 + i));
      n_checks++;
      if (last_pic !== 8'(10 + i) || last_valid !== 1'b1)
        $display("FAIL frame1_px%0d: got last_pic=%0d lv=%b want %0d 1", i, last_pic, last_valid, 10 + i);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    vsync_pulse();
    for (int i = 0; i < FRAME + 2; i++) step(1, 0, 1, 8'($urandom_range(0, 255)));
    n_checks++;
    if (frame_ovf !== 1'b1 || last_valid !== 1'b0) $display("FAIL ovf_set: got ovf=%b lv=%b want 1 0", frame_ovf, last_valid);
    else n_pass++;
    step(1, 0, 0, 8'd0);
    n_checks++;
    if (frame_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", frame_ovf);
    else n_pass++;
    step(1, 1, 0, 8'd0);
    n_checks++;
    if (frame_ovf !== 1'b0 || prev_ok !== 1'b0) $display("FAIL ovf_clear: got ovf=%b prev_ok=%b want 0 0", frame_ovf, prev_ok);
    else n_pass++;
  endtask

  task automatic test_sof_pixel();
    step(1, 0, 0, 8'd0);
    step(1, 1, 1, 8'd77);
    n_checks++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 3'd0) $display("FAIL sof_px_addr0: got en=%b addr=%0d want 1 0", ram_wr_en, ram_wr_addr);
    else n_pass++;
    step(1, 1, 1, 8'd78);
    n_checks++;
    if (ram_wr_addr !== 3'd1) $display("FAIL sof_px_addr1: got %0d want 1", ram_wr_addr);
    else n_pass++;
    for (int i = 2; i < FRAME; i++) step(1, 0, 1, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_mid_reset();
    vsync_pulse();
    n_checks++;
    if (prev_ok !== 1'b1) $display("FAIL midrst_prev_ok: got %b want 1", prev_ok);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'($urandom_range(0, 255)));
    step(0, 0, 1, 8'd200);
    step(1, 0, 0, 8'd0);
    vsync_pulse();
    for (int i = 0; i < FRAME; i++) begin
      step(1, 0, 1, 8'($urandom_range(0, 255)));
      n_checks++;
      if (last_valid !== 1'b0) $display("FAIL midrst_last_valid px%0d: got %b want 0", i, last_valid);
      else n_pass++;
    end
  endtask

  task automatic test_first_frame();
    logic [7:0] ex;
    step(0, 0, 0, 8'd0);
    vsync_pulse();
    ex = gm[0];
`ifdef DIFF_FIRST_FRAME_MASK_EN
    ex = 8'd55;
`endif
    step(1, 0, 1, 8'd55);
    n_checks++;
    if (last_pic !== ex) $display("FAIL first_frame_pic: got %0d want %0d", last_pic, ex);
    else n_pass++;
    for (int i = 1; i < FRAME; i++) step(1, 0, 1, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++) begin
      int npix;
      npix = $urandom_range(FRAME - 2, FRAME + 2);
      if ($urandom_range(0, 1) == 0) begin
        vsync_pulse();
      end else begin
        step(1, 0, 0, 8'd0);
        step(1, 1, 1, 8'($urandom_range(0, 255)));
        npix--;
      end
      for (int i = 0; i < npix; i++) begin
        if ($urandom_range(0, 3) == 0) step(1, 0, 0, 8'($urandom_range(0, 255)));
        step(1, 0, 1, 8'($urandom_range(0, 255)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < FRAME; i++) begin
      ram[i] = 8'd0;
      gm[i]  = 8'd0;
    end
    m_cnt = 0; m_ovf = 1'b0; m_prev_ok = 1'b0; m_vs = 1'b0; m_last = 8'd0;
    @(posedge sys_clk);
    #1;
    test_reset();
    test_frame0();
    test_frame1();
    test_overflow();
    test_sof_pixel();
    test_mid_reset();
    test_first_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
